// File: rtl/dqn_pkg.sv
// Shared types and layer geometry helpers for the DQN weight store.
package dqn_pkg;

    typedef enum logic [1:0] {
        MODE_BWR = 2'b00,
        MODE_BRD = 2'b01,
        MODE_SWR = 2'b10,
        MODE_BAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_SWR
    } state_e;

    localparam int unsigned LAYER_H1  = 1;
    localparam int unsigned LAYER_H2  = 2;
    localparam int unsigned LAYER_OUT = 3;

    // Each node stores its fan-in weights plus one bias word.
    function automatic int unsigned layer_depth(
        input int unsigned layer,
        input int unsigned in_n,
        input int unsigned h1,
        input int unsigned h2,
        input int unsigned out_n
    );
        case (layer)
            LAYER_H1:  return h1 * (in_n + 1);
            LAYER_H2:  return h2 * (h1 + 1);
            LAYER_OUT: return out_n * (h2 + 1);
            default:   return 0;
        endcase
    endfunction

    function automatic int unsigned layer_base(
        input int unsigned layer,
        input int unsigned in_n,
        input int unsigned h1,
        input int unsigned h2,
        input int unsigned out_n
    );
        case (layer)
            LAYER_H2:  return h1 * (in_n + 1);
            LAYER_OUT: return h1 * (in_n + 1) + h2 * (h1 + 1);
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/weight_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with
// a read-enabled output register (holds its word while re is low).
module weight_sdp_ram #(
    parameter int DW    = 32,
    parameter int AW    = 11,
    parameter int DEPTH = 1251
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    (* ram_style = "block" *) logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/weight_bank_ctrl.sv
// Weight store controller: burst write, back-pressured burst read and
// single-word update over one block RAM holding all layers.
module weight_bank_ctrl
    import dqn_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int LAYER_WIDTH   = 2,
    parameter int NUM_LAYERS    = 3,
    parameter int INPUT_NODES   = 2,
    parameter int HIDDEN1_NODES = 32,
    parameter int HIDDEN2_NODES = 32,
    parameter int OUTPUT_NODES  = 3,
    localparam int DEPTH_L1   = HIDDEN1_NODES * (INPUT_NODES + 1),
    localparam int DEPTH_L2   = HIDDEN2_NODES * (HIDDEN1_NODES + 1),
    localparam int DEPTH_L3   = OUTPUT_NODES * (HIDDEN2_NODES + 1),
    localparam int TOTAL      = DEPTH_L1 + DEPTH_L2 + DEPTH_L3,
    localparam int ADDR_WIDTH = $clog2(TOTAL)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic [LAYER_WIDTH-1:0] i_layer,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0]  i_weight,
    input  logic                   i_weight_valid,
    output logic                   o_weight_ready,
    output logic [DATA_WIDTH-1:0]  o_weight,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error
);

    localparam int CW = ADDR_WIDTH + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   base_q, base_d;
    logic [CW-1:0]   depth_q, depth_d;
    logic            valid_q, valid_d;
    logic            wdone_q, wdone_d;
    logic            err_q, err_d;

    mode_e           mode;
    logic [CW-1:0]   sel_base, sel_depth;
    logic            layer_ok, cmd_ok;
    logic            advance, rd_issue, rd_last;
    logic            bw_fire, sw_fire;
    logic            ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign mode = mode_e'(i_mode);

    always_comb begin
        sel_base  = CW'(layer_base(32'(i_layer), INPUT_NODES,
                        HIDDEN1_NODES, HIDDEN2_NODES, OUTPUT_NODES));
        sel_depth = CW'(layer_depth(32'(i_layer), INPUT_NODES,
                        HIDDEN1_NODES, HIDDEN2_NODES, OUTPUT_NODES));
    end

    assign layer_ok = (i_layer != '0) && (int'(i_layer) <= NUM_LAYERS);
    assign cmd_ok   = layer_ok && (mode != MODE_BAD) &&
                      !((mode == MODE_SWR) && ({1'b0, i_addr} >= sel_depth));

    // Only one word is ever in flight: RAM output register is the skid.
    assign advance  = !valid_q || i_ready;
    assign rd_issue = (state_q == ST_READ) && advance && (cnt_q != depth_q);
    assign rd_last  = (state_q == ST_READ) && valid_q && i_ready &&
                      (cnt_q == depth_q);
    assign bw_fire  = (state_q == ST_WRITE) && i_weight_valid;
    assign sw_fire  = (state_q == ST_IDLE) && i_start && cmd_ok &&
                      (mode == MODE_SWR);

    assign ram_we    = bw_fire || sw_fire;
    assign ram_waddr = sw_fire ? ADDR_WIDTH'(sel_base + {1'b0, i_addr})
                               : ADDR_WIDTH'(base_q + cnt_q);
    assign ram_raddr = ADDR_WIDTH'(base_q + cnt_q);

    weight_sdp_ram #(
        .DW    (DATA_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (TOTAL)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (i_weight),
        .re    (rd_issue),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            depth_q <= '0;
            valid_q <= 1'b0;
            wdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            depth_q <= depth_d;
            valid_q <= valid_d;
            wdone_q <= wdone_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        depth_d = depth_q;
        valid_d = valid_q;
        wdone_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (!cmd_ok) begin
                        err_d = 1'b1;
                    end else begin
                        base_d  = sel_base;
                        depth_d = sel_depth;
                        cnt_d   = '0;
                        case (mode)
                            MODE_BWR: state_d = ST_WRITE;
                            MODE_BRD: state_d = ST_READ;
                            default:  state_d = ST_SWR;
                        endcase
                    end
                end
            end
            ST_WRITE: begin
                if (i_weight_valid) begin
                    if (cnt_q == depth_q - 1'b1) begin
                        cnt_d   = '0;
                        wdone_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (advance) begin
                    valid_d = rd_issue;
                end
                if (rd_issue) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (rd_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (state_q != ST_IDLE);
        o_weight_ready = (state_q == ST_WRITE);
        o_valid        = valid_q;
        o_weight       = valid_q ? ram_rdata : '0;
        o_done         = wdone_q || rd_last || (state_q == ST_SWR);
        o_error        = err_q;
    end

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// Directed bench for weight_bank_ctrl with a reference memory model
// and a read-data scoreboard queue.
module tb_weight_bank_ctrl;

    localparam int D1 = 96;
    localparam int D2 = 1056;
    localparam int D3 = 99;
    localparam int B1 = 0;
    localparam int B2 = 96;
    localparam int B3 = 1152;
    localparam int TOT = 1251;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [1:0]  i_layer;
    logic [10:0] i_addr;
    logic [31:0] i_weight;
    logic        i_weight_valid;
    logic        o_weight_ready;
    logic [31:0] o_weight;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    logic [31:0] model [TOT];
    int total;
    int bad;

    weight_bank_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_mode         (i_mode),
        .i_layer        (i_layer),
        .i_addr         (i_addr),
        .i_weight       (i_weight),
        .i_weight_valid (i_weight_valid),
        .o_weight_ready (o_weight_ready),
        .o_weight       (o_weight),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_weight"}, o_weight, 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_ready"}, 32'(o_weight_ready), 32'd0);
        check({tag, "_error"}, 32'(o_error), 32'd0);
    endtask

    task automatic do_write(input int layer, input int base, input int depth,
                            input logic [31:0] pat, input bit gaps);
        int n;
        int cyc;
        bit v;
        n = 0;
        cyc = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_mode  = 2'b00;
        i_layer = 2'(layer);
        @(negedge clk);
        i_start = 1'b0;
        while (n < depth && cyc < 4 * depth + 20) begin
            v = gaps ? ((cyc % 5) != 4) : 1'b1;
            i_weight_valid = v;
            i_weight = pat + 32'(n);
            #1;
            check("wr_ready", 32'(o_weight_ready), 32'd1);
            check("wr_early_done", 32'(o_done), 32'd0);
            @(negedge clk);
            if (v) begin
                model[base + n] = pat + 32'(n);
                n++;
            end
            cyc++;
        end
        i_weight_valid = 1'b0;
        #1;
        check("wr_count", 32'(n), 32'(depth));
        check("wr_done", 32'(o_done), 32'd1);
        check("wr_busy_after", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("wr_done_pulse", 32'(o_done), 32'd0);
    endtask

    task automatic do_read(input int layer, input int base, input int depth,
                           input bit stall, input int abort_at);
        logic [31:0] exp_q [$];
        logic [31:0] held;
        logic [31:0] exp;
        bit hold;
        bit seen;
        bit fin;
        int beats;
        int cyc;
        int first;
        int gaps;
        hold = 0;
        seen = 0;
        fin = 0;
        beats = 0;
        first = -1;
        gaps = 0;
        held = '0;
        @(negedge clk);
        i_start = 1'b1;
        i_mode  = 2'b01;
        i_layer = 2'(layer);
        i_ready = 1'b1;
        for (int i = 0; i < depth; i++) exp_q.push_back(model[base + i]);
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 4 * depth + 20) begin
            i_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (o_valid) begin
                if (!seen) begin
                    seen = 1;
                    first = cyc;
                end
                if (hold) check("rd_stable", o_weight, held);
                if (i_ready) begin
                    exp = exp_q.pop_front();
                    check("rd_data", o_weight, exp);
                    beats++;
                    check("rd_done", 32'(o_done), 32'(exp_q.size() == 0));
                    fin = (exp_q.size() == 0);
                    hold = 0;
                    if (beats == abort_at) begin
                        rst_n = 1'b0;
                        #1;
                        check_idle_outputs("rst_mid");
                        @(negedge clk);
                        check_idle_outputs("rst_hold");
                        rst_n = 1'b1;
                        i_ready = 1'b1;
                        return;
                    end
                end else begin
                    hold = 1;
                    held = o_weight;
                end
            end else if (seen) begin
                gaps++;
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) check("rd_timeout", 32'd0, 32'd1);
        check("rd_beats", 32'(beats), 32'(depth));
        check("rd_first_lat", 32'(first), 32'd2);
        if (!stall) check("rd_gaps", 32'(gaps), 32'd0);
        #1;
        check("rd_busy_after", 32'(o_busy), 32'd0);
        check("rd_valid_after", 32'(o_valid), 32'd0);
        check("rd_done_after", 32'(o_done), 32'd0);
    endtask

    task automatic bad_cmd(input string tag, input logic [1:0] mode,
                           input logic [1:0] layer, input logic [10:0] addr);
        @(negedge clk);
        i_start  = 1'b1;
        i_mode   = mode;
        i_layer  = layer;
        i_addr   = addr;
        i_weight = 32'hBAD0_BAD0;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check({tag, "_error"}, 32'(o_error), 32'd1);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        @(negedge clk);
        check({tag, "_error_pulse"}, 32'(o_error), 32'd0);
        check({tag, "_busy2"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_mode = 2'b00;
        i_layer = 2'd0;
        i_addr = '0;
        i_weight = '0;
        i_weight_valid = 1'b0;
        i_ready = 1'b0;
        for (int i = 0; i < TOT; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        do_write(1, B1, D1, 32'd0, 1'b0);
        do_read(1, B1, D1, 1'b0, -1);

        do_write(3, B3, D3, 32'h3000_0000, 1'b1);
        do_read(3, B3, D3, 1'b1, -1);

        do_write(2, B2, D2, 32'h2000_0000, 1'b0);

        @(negedge clk);
        i_start  = 1'b1;
        i_mode   = 2'b10;
        i_layer  = 2'd2;
        i_addr   = 11'd5;
        i_weight = 32'h0000_DEAD;
        model[B2 + 5] = 32'h0000_DEAD;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check("swr_done", 32'(o_done), 32'd1);
        check("swr_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        check("swr_done_pulse", 32'(o_done), 32'd0);
        check("swr_idle", 32'(o_busy), 32'd0);

        bad_cmd("err_layer0", 2'b10, 2'd0, 11'd0);
        bad_cmd("err_mode11", 2'b11, 2'd1, 11'd0);
        bad_cmd("err_addr", 2'b10, 2'd2, 11'd1056);

        do_read(2, B2, D2, 1'b0, -1);
        do_read(1, B1, D1, 1'b1, -1);
        do_read(3, B3, D3, 1'b0, -1);

        do_read(2, B2, D2, 1'b1, 40);
        do_read(2, B2, D2, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
